// File: rtl/adpll_pkg.sv
// adpll_pkg: shared loop-filter state encoding and sizing/saturation helpers.
//   lf_state_t : loop-filter FSM state (IDLE, ACQUIRE, LOCKED)
//   lf_center  : DCO mid-scale code for a given control width
//   lf_int_w   : integrator width for a given control width and integral shift
//   sat_s      : signed clamp of an int to [lo, hi]
package adpll_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} lf_state_t;
  function automatic int lf_center(input int ctrl_w);
    return 1 << (ctrl_w - 1);
  endfunction
  function automatic int lf_int_w(input int ctrl_w, input int ki_shift);
    return ctrl_w + ki_shift + 1;
  endfunction
  function automatic int sat_s(input int x, input int lo, input int hi);
    return x < lo ? lo : x > hi ? hi : x;
  endfunction
endpackage

// File: rtl/adpll_lock_detect.sv
// adpll_lock_detect: hysteretic lock-detect FSM with in/out tolerance counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : loop enable; low forces IDLE and clears counters
//   upd        : one strobe per filter update
//   in_tol     : the error of this update is within tolerance
//   state      : current FSM state
//   locked     : high while in LOCKED
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  logic      upd,
  input  logic      in_tol,
  output lf_state_t state,
  output logic      locked
);
  localparam int CW = $clog2((LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT) + 1);
  lf_state_t state_nxt;
  logic [CW-1:0] in_cnt, out_cnt, in_nxt, out_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      state   <= state_nxt;
      in_cnt  <= in_nxt;
      out_cnt <= out_nxt;
    end
  always_comb begin
    state_nxt = state;
    in_nxt    = in_cnt;
    out_nxt   = out_cnt;
    if (!en) begin
      state_nxt = IDLE;
      in_nxt    = '0;
      out_nxt   = '0;
    end else
      case (state)
        IDLE: state_nxt = ACQUIRE;
        ACQUIRE:
          if (upd) begin
            in_nxt = in_tol ? in_cnt + 1'b1 : '0;
            if (in_tol && in_cnt == CW'(LOCK_CNT - 1)) begin
              state_nxt = LOCKED;
              in_nxt    = '0;
              out_nxt   = '0;
            end
          end
        LOCKED:
          if (upd) begin
            out_nxt = in_tol ? '0 : out_cnt + 1'b1;
            if (!in_tol && out_cnt == CW'(UNLOCK_CNT - 1)) begin
              state_nxt = ACQUIRE;
              in_nxt    = '0;
              out_nxt   = '0;
            end
          end
        default: state_nxt = IDLE;
      endcase
  end
  assign locked = state == LOCKED;
endmodule

// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter: ADPLL PI loop filter, phase word in, DCO tuning word out.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : loop enable; low holds the DCO at mid-scale
//   sample_valid : tdc_count/target valid strobe
//   tdc_count    : measured phase word
//   target       : desired phase word
//   dco_ctrl     : registered DCO tuning word
//   ctrl_valid   : strobe on each dco_ctrl update (two cycles after a sample)
//   phase_err    : registered signed target - tdc_count of the last accepted sample
//   locked       : lock indicator
module adpll_loop_filter
  import adpll_pkg::*;
#(
  parameter int CNT_W      = 5,
  parameter int CTRL_W     = 8,
  parameter int KP_SHIFT   = 1,
  parameter int KI_SHIFT   = 3,
  parameter int LOCK_TOL   = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sample_valid,
  input  logic [CNT_W-1:0]        tdc_count,
  input  logic [CNT_W-1:0]        target,
  output logic [CTRL_W-1:0]       dco_ctrl,
  output logic                    ctrl_valid,
  output logic signed [CNT_W:0]   phase_err,
  output logic                    locked
);
  localparam int CENTER = lf_center(CTRL_W);
  localparam int INT_W  = lf_int_w(CTRL_W, KI_SHIFT);
  localparam int IMAX   = (1 << (INT_W - 1)) - 1;
  localparam int IMIN   = -(1 << (INT_W - 1));
  localparam int CMAX   = (1 << CTRL_W) - 1;
  lf_state_t state;
  logic signed [CNT_W:0] err;
  logic signed [INT_W-1:0] integ;
  logic v1, accept, upd, in_tol;
  int e_i, integ_i, sum_i;
  assign err    = $signed({1'b0, target}) - $signed({1'b0, tdc_count});
  assign accept = en && sample_valid && state != IDLE;
  assign upd    = v1 && en;
  // Whole datapath in 32-bit int so the sum never wraps before the final clamp.
  always_comb begin
    e_i     = int'(phase_err);
    integ_i = sat_s(int'(integ) + e_i, IMIN, IMAX);
    sum_i   = CENTER + (e_i <<< KP_SHIFT) + (integ_i >>> KI_SHIFT);
    in_tol  = e_i <= LOCK_TOL && e_i >= -LOCK_TOL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1         <= 1'b0;
      phase_err  <= '0;
      ctrl_valid <= 1'b0;
      integ      <= '0;
      dco_ctrl   <= CTRL_W'(CENTER);
    end else begin
      v1         <= accept;
      ctrl_valid <= upd;
      if (accept) phase_err <= err;
      if (!en || state == IDLE) begin
        integ    <= '0;
        dco_ctrl <= CTRL_W'(CENTER);
      end else if (upd) begin
        integ    <= INT_W'(integ_i);
        dco_ctrl <= CTRL_W'(sat_s(sum_i, 0, CMAX));
      end
    end
  adpll_lock_detect #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT)
  ) u_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .upd   (upd),
    .in_tol(in_tol),
    .state (state),
    .locked(locked)
  );
endmodule
